// File: rtl/onehot_monitor.sv
// rtl/onehot_monitor.sv - registered zero/one-hot/multi-hot classifier with hot-bit index,
// saturating violation counter and sticky run-length alarm.
module onehot_monitor #(
  parameter int WIDTH      = 8,
  parameter int ERR_THRESH = 3,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s,
  input  logic             clr,
  output logic             out_valid,
  output logic             zero,
  output logic             valid,
  output logic             multi,
  output logic [IDX_W-1:0] index,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm
);

  localparam int RUN_W = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {OK, WARN, ALARM} state_t;

  state_t           state, state_next;
  logic [RUN_W-1:0] run, run_next;
  logic [CNT_W-1:0] err_next;
  logic             s_zero, s_multi;
  logic [IDX_W-1:0] s_index;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign s_zero  = (s == '0);
  assign s_multi = |(s & (s - WIDTH'(1)));

  always_comb begin
    s_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i]) s_index = IDX_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    run_next   = run;
    err_next   = err_cnt;
    if (clr) begin
      state_next = OK;
      run_next   = '0;
      err_next   = '0;
    end else if (in_valid) begin
      if (s_zero || s_multi) begin
        if (err_cnt != '1) err_next = err_cnt + CNT_W'(1);
        if (run != RUN_W'(ERR_THRESH)) run_next = run + RUN_W'(1);
        if (state != ALARM) state_next = (run_next == RUN_W'(ERR_THRESH)) ? ALARM : WARN;
      end else begin
        run_next = '0;
        if (state == WARN) state_next = OK;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OK;
      run       <= '0;
      err_cnt   <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      valid     <= 1'b0;
      multi     <= 1'b0;
      index     <= '0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      err_cnt   <= err_next;
      out_valid <= in_valid;
      // Classification holds its last value across idle cycles.
      if (in_valid) begin
        zero  <= s_zero;
        multi <= s_multi;
        valid <= !s_zero && !s_multi;
        index <= (!s_zero && !s_multi) ? s_index : '0;
      end
    end
  end

  assign alarm = (state == ALARM);

endmodule

// File: tb/tb_onehot_monitor.sv
// tb/tb_onehot_monitor.sv - table-driven directed tests plus randomized comparison of four
// differently parameterised monitors against a counting reference model.
module tb_onehot_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  iv, cl;
  logic [15:0] sv [4];
  wire  [3:0]  ov, zr, vl, mu, al;
  wire  [2:0]  idx_a, idx_b, idx_c;
  wire  [3:0]  idx_d;
  wire  [7:0]  err_a, err_c;
  wire  [1:0]  err_b;
  wire  [3:0]  err_d;

  onehot_monitor #(.WIDTH(8), .ERR_THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .s(sv[0][7:0]), .clr(cl[0]),
    .out_valid(ov[0]), .zero(zr[0]), .valid(vl[0]), .multi(mu[0]), .index(idx_a),
    .err_cnt(err_a), .alarm(al[0]));
  onehot_monitor #(.WIDTH(8), .ERR_THRESH(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .s(sv[1][7:0]), .clr(cl[1]),
    .out_valid(ov[1]), .zero(zr[1]), .valid(vl[1]), .multi(mu[1]), .index(idx_b),
    .err_cnt(err_b), .alarm(al[1]));
  onehot_monitor #(.WIDTH(5), .ERR_THRESH(3), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .s(sv[2][4:0]), .clr(cl[2]),
    .out_valid(ov[2]), .zero(zr[2]), .valid(vl[2]), .multi(mu[2]), .index(idx_c),
    .err_cnt(err_c), .alarm(al[2]));
  onehot_monitor #(.WIDTH(16), .ERR_THRESH(1), .CNT_W(4)) dut_d (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .s(sv[3]), .clr(cl[3]),
    .out_valid(ov[3]), .zero(zr[3]), .valid(vl[3]), .multi(mu[3]), .index(idx_d),
    .err_cnt(err_d), .alarm(al[3]));

  int wid  [4] = '{8, 8, 5, 16};
  int thr  [4] = '{3, 2, 3, 1};
  int cmax [4] = '{255, 3, 255, 15};

  typedef struct {
    bit ov, z, v, mu, al;
    int idx, err, run;
  } mstate_t;

  typedef struct {
    bit iv; logic [15:0] s; bit clr;
    bit ov, z, v, mu; int idx, err; bit al;
  } vec_t;

  int checks = 0;
  int errors = 0;
  mstate_t m [4];

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic mstate_t dut_state(int k);
    mstate_t r;
    r.ov = ov[k]; r.z = zr[k]; r.v = vl[k]; r.mu = mu[k]; r.al = al[k]; r.run = 0;
    case (k)
      0: begin r.idx = int'(idx_a); r.err = int'(err_a); end
      1: begin r.idx = int'(idx_b); r.err = int'(err_b); end
      2: begin r.idx = int'(idx_c); r.err = int'(err_c); end
      default: begin r.idx = int'(idx_d); r.err = int'(err_d); end
    endcase
    return r;
  endfunction

  task automatic check_inst(int k, string tag, bit eov, bit ez, bit ev, bit emu, int eidx, int eerr, bit eal);
    mstate_t d = dut_state(k);
    cmp({tag, ".out_valid"}, d.ov, eov);
    cmp({tag, ".zero"}, d.z, ez);
    cmp({tag, ".valid"}, d.v, ev);
    cmp({tag, ".multi"}, d.mu, emu);
    cmp({tag, ".index"}, d.idx, eidx);
    cmp({tag, ".err_cnt"}, d.err, eerr);
    cmp({tag, ".alarm"}, d.al, eal);
  endtask

  // Reference: count set bits, locate a lone bit by power-of-two search, keep an unbounded run
  // length and latch the alarm once that run reaches the threshold.
  function automatic mstate_t model_step(mstate_t mi, int k, bit i_v, logic [15:0] s, bit c);
    mstate_t mo = mi;
    int n, sm;
    sm = int'(s) & ((1 << wid[k]) - 1);
    n  = $countones(sm);
    if (i_v) begin
      mo.ov = 1; mo.z = (n == 0); mo.v = (n == 1); mo.mu = (n > 1); mo.idx = 0;
      for (int b = 0; b < wid[k]; b++) if (sm == (1 << b)) mo.idx = b;
    end else begin
      mo.ov = 0;
    end
    if (c) begin
      mo.err = 0; mo.run = 0; mo.al = 0;
    end else if (i_v) begin
      if (n != 1) begin
        mo.err = (mo.err + 1 > cmax[k]) ? cmax[k] : mo.err + 1;
        mo.run++;
        if (mo.run >= thr[k]) mo.al = 1;
      end else begin
        mo.run = 0;
      end
    end
    return mo;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, bit i_v, logic [15:0] s, bit c);
    iv[k] = i_v; sv[k] = s; cl[k] = c;
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 16'h10, 0, 1, 0, 1, 0, 4, 0, 0};
    tbl[1]  = '{1, 16'h00, 0, 1, 1, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 16'h41, 0, 1, 0, 0, 1, 0, 2, 0};
    tbl[3]  = '{1, 16'h81, 0, 1, 0, 0, 1, 0, 3, 1};
    tbl[4]  = '{1, 16'h01, 0, 1, 0, 1, 0, 0, 3, 1};
    tbl[5]  = '{1, 16'h80, 0, 1, 0, 1, 0, 7, 3, 1};
    tbl[6]  = '{1, 16'h02, 1, 1, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{1, 16'h00, 0, 1, 1, 0, 0, 0, 1, 0};
    tbl[8]  = '{1, 16'h03, 0, 1, 0, 0, 1, 0, 2, 0};
    tbl[9]  = '{0, 16'hff, 0, 0, 0, 0, 1, 0, 2, 0};
    tbl[10] = '{0, 16'h00, 0, 0, 0, 0, 1, 0, 2, 0};
    tbl[11] = '{1, 16'h20, 0, 1, 0, 1, 0, 5, 2, 0};
    tbl[12] = '{1, 16'h00, 0, 1, 1, 0, 0, 0, 3, 0};
    tbl[13] = '{0, 16'h00, 1, 0, 1, 0, 0, 0, 0, 0};

    rst = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 0, 16'h0, 0);
    tick(); tick();
    for (int k = 0; k < 4; k++) check_inst(k, $sformatf("reset%0d", k), 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int r = 0; r < 14; r++) begin
      drive(0, tbl[r].iv, tbl[r].s, tbl[r].clr);
      tick();
      check_inst(0, $sformatf("table%0d", r), tbl[r].ov, tbl[r].z, tbl[r].v, tbl[r].mu,
                 tbl[r].idx, tbl[r].err, tbl[r].al);
    end

    // Saturation on a 2-bit counter; alarm at the second consecutive violation.
    for (int r = 0; r < 5; r++) begin
      drive(1, 1, 16'h00, 0);
      tick();
      check_inst(1, $sformatf("sat%0d", r), 1, 1, 0, 0, 0, (r < 3) ? r + 1 : 3, r >= 1);
    end
    drive(1, 0, 16'h0, 0);

    // Drive into ALARM, then reset asynchronously between edges.
    for (int r = 0; r < 3; r++) begin
      drive(0, 1, 16'h00, 0);
      tick();
    end
    check_inst(0, "pre_rst", 1, 1, 0, 0, 0, 3, 1);
    #2 rst = 1'b1;
    #1;
    check_inst(0, "async_rst", 0, 0, 0, 0, 0, 0, 0);
    check_inst(1, "async_rst_b", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 16'h0, 0);
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive(0, 1, 16'h06, 0);
      tick();
    end
    check_inst(0, "post_rst_run", 1, 0, 0, 1, 0, 2, 0);

    rst = 1'b1;
    for (int k = 0; k < 4; k++) drive(k, 0, 16'h0, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) m[k] = '{default: 0};

    for (int cyc = 0; cyc < 400; cyc++) begin
      bit do_rst;
      do_rst = ($urandom_range(0, 99) == 0);
      rst = do_rst;
      for (int k = 0; k < 4; k++) begin
        logic [15:0] s;
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
          0: s = 16'h0;
          1: s = 16'h1 << $urandom_range(0, wid[k] - 1);
          2: s = (16'h1 << $urandom_range(0, wid[k] - 1)) | (16'h1 << $urandom_range(0, wid[k] - 1));
          default: s = 16'($urandom);
        endcase
        drive(k, $urandom_range(0, 3) != 0, s, $urandom_range(0, 15) == 0);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (do_rst) m[k] = '{default: 0};
        else m[k] = model_step(m[k], k, iv[k], sv[k], cl[k]);
        check_inst(k, $sformatf("rand%0d_c%0d", k, cyc), m[k].ov, m[k].z, m[k].v, m[k].mu,
                   m[k].idx, m[k].err, m[k].al);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
